spi_px_stream_bridge: RTL



---
 rtl/spi_px_stream_bridge.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_px_stream_bridge.sv
// SPI mode-0 slave oversampled in the system clock domain, bridging serial words
// to/from first-word-fall-through RX/TX FIFOs with sticky overflow/underflow flags.
module spi_px_stream_bridge #(
    parameter int PX_BITS        = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter bit LSB_BYTE_FIRST = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               spi_sck_i,
    input  logic               spi_sdi_i,
    input  logic               spi_cs_i,
    output logic               spi_sdo_o,
    output logic [PX_BITS-1:0] rx_px_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    input  logic [PX_BITS-1:0] tx_px_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic               flags_clr_i,
    output logic               rx_overflow_o,
    output logic               tx_underflow_o,
    output logic               busy_o
);
    localparam int NB = PX_BITS / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PX_BITS);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PX_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // Byte reversal is its own inverse, so it maps word->wire and wire->word.
    function automatic logic [PX_BITS-1:0] byte_perm(input logic [PX_BITS-1:0] w);
        logic [PX_BITS-1:0] r;
        r = w;
        if (LSB_BYTE_FIRST)
            for (int k = 0; k < NB; k++) r[PX_BITS-1-8*k -: 8] = w[8*k +: 8];
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
    logic sck_d, cs_d, sck_fall_q;
    logic sck_s, cs_s, sdi_s, sck_rise, cs_fall;

    state_t state_q, state_d;
    logic load, rise_act, fall_act, tx_reload, tx_pop;
    logic [PX_BITS-1:0] tx_sr, rx_sr, rx_next, push_word, tx_load_word;
    logic [CW-1:0] bit_cnt;
    logic push_q;

    logic [PX_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PX_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic rx_full, rx_empty, tx_full, tx_empty, rx_pop, rx_wr, rx_drop, tx_wr;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign cs_fall  = cs_d & ~cs_s;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_sync   <= '0;
            cs_sync    <= '0;
            sdi_sync   <= '0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b0;
            sck_fall_q <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
            sck_d      <= sck_s;
            cs_d       <= cs_s;
            // Falls act one cycle later so MISO lines up with the LOAD path.
            sck_fall_q <= sck_d & ~sck_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        rise_act = 1'b0;
        fall_act = 1'b0;
        if (cs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = LOAD;
                LOAD:    begin load = 1'b1; state_d = SHIFT; end
                SHIFT:   begin rise_act = sck_rise; fall_act = sck_fall_q; end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);

    assign tx_reload    = load | (fall_act & (bit_cnt == '0));
    assign tx_pop       = tx_reload & ~tx_empty;
    assign tx_load_word = tx_empty ? '0 : byte_perm(tx_mem[tx_rp[AW-1:0]]);
    assign rx_next      = {rx_sr[PX_BITS-2:0], sdi_s};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            spi_sdo_o <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= 1'b0;
            if (state_d == IDLE) begin
                spi_sdo_o <= 1'b0;
                bit_cnt   <= '0;
            end else if (tx_reload) begin
                tx_sr     <= tx_load_word;
                spi_sdo_o <= tx_load_word[PX_BITS-1];
                if (load) bit_cnt <= '0;
            end else if (fall_act) begin
                tx_sr     <= tx_sr << 1;
                spi_sdo_o <= tx_sr[PX_BITS-2];
            end
            if (rise_act) begin
                rx_sr <= rx_next;
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt   <= '0;
                    push_q    <= 1'b1;
                    push_word <= byte_perm(rx_next);
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    assign rx_valid_o = ~rx_empty;
    assign rx_px_o    = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign rx_wr      = push_q & (~rx_full | rx_pop);
    assign rx_drop    = push_q & rx_full & ~rx_pop;
    assign tx_ready_o = ~tx_full;
    assign tx_wr      = tx_valid_i & tx_ready_o;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_wp          <= '0;
            rx_rp          <= '0;
            tx_wp          <= '0;
            tx_rp          <= '0;
            rx_overflow_o  <= 1'b0;
            tx_underflow_o <= 1'b0;
        end else begin
            if (rx_wr) begin
                rx_mem[rx_wp[AW-1:0]] <= push_word;
                rx_wp <= rx_wp + PTR_ONE;
            end
            if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
            if (tx_wr) begin
                tx_mem[tx_wp[AW-1:0]] <= tx_px_i;
                tx_wp <= tx_wp + PTR_ONE;
            end
            if (tx_pop) tx_rp <= tx_rp + PTR_ONE;
            rx_overflow_o  <= rx_drop | (rx_overflow_o & ~flags_clr_i);
            tx_underflow_o <= (tx_reload & tx_empty) | (tx_underflow_o & ~flags_clr_i);
        end
    end
endmodule
